shift_add_seq: RTL and testbench

Sequencing and accumulation stage of the 16x9 sequential multiplier, directly upstream of the 8-bit low-product shift register.
- Runs a shift-and-add multiply: one multiplier bit per cycle, nine cycles per operation.
- Drives the shift register's CLR_ACC, SFT_IN and D_OUT inputs, so the shift register ends each operation holding product[7:0].
- Holds the upper product bits, product[24:8], itself.
- Provides a START/BUSY/DONE handshake to the surrounding control.

---
 rtl/shift_add_seq.sv | 140 ++++++++++++++
 tb/tb_shift_add_seq.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_add_seq.sv
// shift_add_seq
//   Sequencing and accumulation stage of a 16x9 shift-and-add multiplier.
//   It retires one multiplier bit per RUN cycle. The low LOW_W product bits
//   are streamed LSB-first into an external shift register (CLR_ACC/SFT_IN/D_OUT).
//   The upper product bits are kept here in PROD_HI.
// Ports:
//   CLK, RST        rising-edge clock, synchronous active-high reset
//   START           multiply request, sampled only in IDLE
//   MCAND, MPLR     operands, captured when START is accepted
//   BUSY, DONE      handshake: BUSY in LOAD/RUN, DONE one-cycle result pulse
//   CLR_ACC         clear strobe to the shift register (LOAD or RST)
//   SFT_IN, D_OUT   shift enable and product bit for the shift register
//   PROD_HI         product[MCAND_W+MPLR_W-1:LOW_W]
module shift_add_seq #(
   parameter int MCAND_W = 16,
   parameter int MPLR_W  = 9,
   parameter int LOW_W   = 8
) (
   input  logic                              CLK,
   input  logic                              RST,
   input  logic                              START,
   input  logic [MCAND_W-1:0]                MCAND,
   input  logic [MPLR_W-1:0]                 MPLR,
   output logic                              BUSY,
   output logic                              DONE,
   output logic                              CLR_ACC,
   output logic                              SFT_IN,
   output logic                              D_OUT,
   output logic [MCAND_W+MPLR_W-LOW_W-1:0]   PROD_HI
);

   localparam int         HI_W     = MCAND_W + MPLR_W - LOW_W;
   localparam int         S_W      = MCAND_W + 1;
   localparam logic [3:0] CNT_LAST = 4'(MPLR_W - 1);
   localparam logic [3:0] CNT_LOW  = 4'(LOW_W);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   state_e               state_q;
   logic [MCAND_W-1:0]   m_q;
   logic [MPLR_W-1:0]    q_q;
   logic [MCAND_W-1:0]   a_q;
   logic [3:0]           cnt_q;
   logic [HI_W-1:0]      hi_q;
   logic                 busy_q;
   logic                 done_q;
   logic                 sft_q;

   logic [S_W-1:0]       s_d;
   logic [MCAND_W-1:0]   a_d;
   logic [MPLR_W-1:0]    q_d;
   logic [3:0]           cnt_d;

   // Partial product sum; the carry bit lands in s_d[MCAND_W], so nothing overflows.
   assign s_d   = {1'b0, a_q} + (q_q[0] ? {1'b0, m_q} : {S_W{1'b0}});
   assign a_d   = s_d[MCAND_W:1];
   assign q_d   = q_q >> 1;
   assign cnt_d = cnt_q + 4'd1;

   // Sequencer and datapath registers. BUSY/DONE/SFT_IN are registered from the next state.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_IDLE;
         m_q     <= {MCAND_W{1'b0}};
         q_q     <= {MPLR_W{1'b0}};
         a_q     <= {MCAND_W{1'b0}};
         cnt_q   <= 4'd0;
         hi_q    <= {HI_W{1'b0}};
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sft_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               done_q <= 1'b0;
               sft_q  <= 1'b0;
               if (START) begin
                  m_q     <= MCAND;
                  q_q     <= MPLR;
                  a_q     <= {MCAND_W{1'b0}};
                  cnt_q   <= 4'd0;
                  busy_q  <= 1'b1;
                  state_q <= ST_LOAD;
               end else begin
                  busy_q  <= 1'b0;
               end
            end
            ST_LOAD: begin
               busy_q  <= 1'b1;
               done_q  <= 1'b0;
               sft_q   <= (4'd0 < CNT_LOW);
               state_q <= ST_RUN;
            end
            ST_RUN: begin
               a_q   <= a_d;
               q_q   <= q_d;
               cnt_q <= cnt_d;
               if (cnt_q == CNT_LAST) begin
                  // {final accumulator, current product bit} is the whole upper product.
                  hi_q    <= HI_W'(s_d);
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  sft_q   <= 1'b0;
                  state_q <= ST_DONE;
               end else begin
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
                  sft_q   <= (cnt_d < CNT_LOW);
               end
            end
            ST_DONE: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               sft_q   <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               sft_q   <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // CLR_ACC follows RST directly so the shift register is cleared in the same edge as this block.
   assign CLR_ACC = RST | (state_q == ST_LOAD);
   assign BUSY    = busy_q;
   assign DONE    = done_q;
   assign SFT_IN  = sft_q;
   assign D_OUT   = s_d[0];
   assign PROD_HI = hi_q;

endmodule

// File: tb/tb_shift_add_seq.sv
// tb_shift_add_seq
//   Directed vector table, reset/handshake sequences and random operands for
//   shift_add_seq. It includes a behavioural model of the downstream 8-bit
//   shift register, which inserts at the MSB.
module tb_shift_add_seq;

   logic        CLK;
   logic        RST;
   logic        START;
   logic [15:0] MCAND;
   logic [8:0]  MPLR;
   logic        BUSY;
   logic        DONE;
   logic        CLR_ACC;
   logic        SFT_IN;
   logic        D_OUT;
   logic [16:0] PROD_HI;

   logic [7:0]  sr_q;
   int          n_tests;
   int          n_fail;

   shift_add_seq dut (
      .CLK     (CLK),
      .RST     (RST),
      .START   (START),
      .MCAND   (MCAND),
      .MPLR    (MPLR),
      .BUSY    (BUSY),
      .DONE    (DONE),
      .CLR_ACC (CLR_ACC),
      .SFT_IN  (SFT_IN),
      .D_OUT   (D_OUT),
      .PROD_HI (PROD_HI)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Downstream low-product shift register model.
   always @(posedge CLK) begin
      if (CLR_ACC) sr_q <= 8'h00;
      else if (SFT_IN) sr_q <= {D_OUT, sr_q[7:1]};
   end

   typedef struct {
      logic [15:0] mc;
      logic [8:0]  mp;
      logic [16:0] hi;
      logic [7:0]  lo;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   // Starts one multiply from IDLE and checks latency, BUSY/SFT_IN counts and the result.
   // With interfere set, START stays high through RUN and DONE with junk operands.
   task automatic run_op(input logic [15:0] mc, input logic [8:0] mp,
                         input logic [16:0] exp_hi, input logic [7:0] exp_lo,
                         input bit interfere, input string tag);
      int   done_cyc;
      int   busy_n;
      int   sft_n;
      logic sft10;
      done_cyc = 0;
      busy_n   = 0;
      sft_n    = 0;
      sft10    = 1'b1;
      @(negedge CLK);
      START = 1'b1;
      MCAND = mc;
      MPLR  = mp;
      for (int c = 1; c <= 20 && done_cyc == 0; c++) begin
         @(negedge CLK);
         START = interfere;
         MCAND = 16'($urandom);
         MPLR  = 9'($urandom);
         busy_n += int'(BUSY);
         sft_n  += int'(SFT_IN);
         if (c == 10) sft10 = SFT_IN;
         if (DONE) done_cyc = c;
      end
      check({tag, "_latency"}, 32'(done_cyc), 32'd11);
      check({tag, "_busy_cycles"}, 32'(busy_n), 32'd10);
      check({tag, "_sft_cycles"}, 32'(sft_n), 32'd8);
      check({tag, "_sft_run9"}, 32'(sft10), 32'd0);
      check({tag, "_prod_hi"}, 32'(PROD_HI), 32'(exp_hi));
      check({tag, "_shiftreg"}, 32'(sr_q), 32'(exp_lo));
      if (interfere) begin
         @(negedge CLK);
         START = 1'b0;
         check({tag, "_idle_busy"}, 32'(BUSY), 32'd0);
         check({tag, "_done_pulse"}, 32'(DONE), 32'd0);
         @(negedge CLK);
         check({tag, "_no_queued_start"}, 32'(BUSY), 32'd0);
      end else begin
         START = 1'b0;
      end
   endtask

   initial begin
      logic [15:0] mc;
      logic [8:0]  mp;
      logic [24:0] prod;
      int          dn;
      int          last_done;
      int          done_n;

      n_tests = 0;
      n_fail  = 0;
      RST     = 1'b1;
      START   = 1'b0;
      MCAND   = 16'h0000;
      MPLR    = 9'h000;

      vecs[0] = '{16'hFFFF, 9'h1FF, 17'h1FEFE, 8'h01};
      vecs[1] = '{16'h1234, 9'h0A5, 17'h00BBB, 8'h84};
      vecs[2] = '{16'hABCD, 9'h001, 17'h000AB, 8'hCD};
      vecs[3] = '{16'h0000, 9'h155, 17'h00000, 8'h00};
      vecs[4] = '{16'h0001, 9'h100, 17'h00001, 8'h00};
      vecs[5] = '{16'h00FF, 9'h002, 17'h00001, 8'hFE};
      vecs[6] = '{16'h8000, 9'h100, 17'h08000, 8'h00};
      vecs[7] = '{16'hFFFF, 9'h000, 17'h00000, 8'h00};
      vecs[8] = '{16'h0003, 9'h0FF, 17'h00002, 8'hFD};

      // Reset state.
      repeat (3) @(negedge CLK);
      check("rst_busy", 32'(BUSY), 32'd0);
      check("rst_done", 32'(DONE), 32'd0);
      check("rst_sft_in", 32'(SFT_IN), 32'd0);
      check("rst_prod_hi", 32'(PROD_HI), 32'd0);
      check("rst_clr_acc", 32'(CLR_ACC), 32'd1);
      RST = 1'b0;
      @(negedge CLK);
      check("idle_clr_acc", 32'(CLR_ACC), 32'd0);

      // Directed vectors.
      for (int i = 0; i < 9; i++) begin
         run_op(vecs[i].mc, vecs[i].mp, vecs[i].hi, vecs[i].lo, 1'b0, $sformatf("vec%0d", i));
      end

      // START pulsed during RUN and DONE with other operands is ignored.
      run_op(16'h1234, 9'h0A5, 17'h00BBB, 8'h84, 1'b1, "interfere");

      // Leave a non-zero PROD_HI, then reset mid-RUN.
      run_op(16'hABCD, 9'h001, 17'h000AB, 8'hCD, 1'b0, "pre_rst");
      @(negedge CLK);
      START = 1'b1;
      MCAND = 16'hFFFF;
      MPLR  = 9'h1FF;
      @(negedge CLK);
      START = 1'b0;
      repeat (4) @(negedge CLK);
      check("mid_run_busy", 32'(BUSY), 32'd1);
      RST = 1'b1;
      #1;
      check("rst_clr_acc_comb", 32'(CLR_ACC), 32'd1);
      @(negedge CLK);
      check("rst_mid_clr_acc", 32'(CLR_ACC), 32'd1);
      check("rst_mid_busy", 32'(BUSY), 32'd0);
      check("rst_mid_done", 32'(DONE), 32'd0);
      check("rst_mid_prod_hi", 32'(PROD_HI), 32'd0);
      check("rst_mid_shiftreg", 32'(sr_q), 32'd0);
      RST = 1'b0;
      dn = 0;
      for (int c = 0; c < 15; c++) begin
         @(negedge CLK);
         dn += int'(DONE) + int'(BUSY);
      end
      check("rst_abort_no_done", 32'(dn), 32'd0);

      // START held high: back-to-back operations, DONE every 12 cycles.
      @(negedge CLK);
      START     = 1'b1;
      MCAND     = 16'h1234;
      MPLR      = 9'h0A5;
      last_done = -1;
      done_n    = 0;
      for (int c = 1; c <= 60; c++) begin
         @(negedge CLK);
         if (DONE) begin
            done_n++;
            if (last_done < 0) check("held_first_done", 32'(c), 32'd11);
            else check("held_done_period", 32'(c - last_done), 32'd12);
            check("held_prod_hi", 32'(PROD_HI), 32'h00BBB);
            check("held_shiftreg", 32'(sr_q), 32'h84);
            last_done = c;
         end
         if (c == 60) START = 1'b0;
      end
      check("held_done_count", 32'(done_n), 32'd5);
      @(negedge CLK);
      check("held_stop_busy", 32'(BUSY), 32'd0);

      // Random operands against the product.
      for (int i = 0; i < 1000; i++) begin
         mc   = 16'($urandom);
         mp   = 9'($urandom);
         prod = 25'(mc) * 25'(mp);
         run_op(mc, mp, prod[24:8], prod[7:0], 1'b0, "rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
